// File: rtl/key_tone_gen.sv
// Square-wave tone synthesiser: picks the highest-priority held key and emits one
// enveloped PCM sample per sample tick into the codec FIFO via a ready/write handshake.
module key_tone_gen #(
    parameter int SAMPLE_DIV = 1042,
    parameter int AMP_STEP   = 4,
    parameter int AMP_SHIFT  = 20
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] keys,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [3:0]  note,
    output logic        overrun
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {SILENT, PLAY, RELEASE} state_t;

    state_t        state, nxt_state;
    logic [15:0]   keys_q;
    logic [CW-1:0] count;
    logic [7:0]    amp, nxt_amp, amp_up, amp_dn;
    logic [8:0]    amp_sum;
    logic [6:0]    phase, nxt_phase, adv_phase;
    logic          pol, nxt_pol, adv_pol;
    logic [3:0]    nxt_note, sel;
    logic          any_key, tick, pending;
    logic [31:0]   mag, sample;

    // Half period in sample ticks, index 15 (q, C4) down to 0 (h, D#5).
    function automatic logic [6:0] half_period(input logic [3:0] n);
        case (n)
            4'd15:   return 7'd92;
            4'd14:   return 7'd87;
            4'd13:   return 7'd82;
            4'd12:   return 7'd77;
            4'd11:   return 7'd73;
            4'd10:   return 7'd69;
            4'd9:    return 7'd65;
            4'd8:    return 7'd61;
            4'd7:    return 7'd58;
            4'd6:    return 7'd55;
            4'd5:    return 7'd51;
            4'd4:    return 7'd49;
            4'd3:    return 7'd46;
            4'd2:    return 7'd43;
            4'd1:    return 7'd41;
            default: return 7'd39;
        endcase
    endfunction

    assign any_key = |keys_q;
    assign tick    = (count == LAST);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = '0;
        for (int i = 0; i < 16; i++) begin
            if (keys_q[i]) sel = 4'(i);
        end
    end

    always_comb begin
        amp_sum = {1'b0, amp} + 9'(AMP_STEP);
        amp_up  = amp_sum[8] ? 8'hFF : amp_sum[7:0];
        amp_dn  = (amp <= 8'(AMP_STEP)) ? 8'd0 : amp - 8'(AMP_STEP);
        if (phase == half_period(note) - 7'd1) begin
            adv_phase = '0;
            adv_pol   = ~pol;
        end else begin
            adv_phase = phase + 7'd1;
            adv_pol   = pol;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_amp   = amp;
        nxt_phase = phase;
        nxt_pol   = pol;
        nxt_note  = note;
        case (state)
            SILENT: begin
                nxt_amp = '0;
                if (any_key) begin
                    nxt_state = PLAY;
                    nxt_note  = sel;
                    nxt_phase = '0;
                    nxt_pol   = 1'b1;
                end
            end
            PLAY: begin
                nxt_amp = amp_up;
                if (!any_key) begin
                    nxt_state = RELEASE;
                    nxt_phase = adv_phase;
                    nxt_pol   = adv_pol;
                end else if (sel != note) begin
                    // Note change restarts the waveform but keeps polarity and envelope continuous.
                    nxt_note  = sel;
                    nxt_phase = '0;
                end else begin
                    nxt_phase = adv_phase;
                    nxt_pol   = adv_pol;
                end
            end
            RELEASE: begin
                if (any_key) begin
                    nxt_state = PLAY;
                    nxt_note  = sel;
                    nxt_phase = '0;
                end else begin
                    nxt_amp   = amp_dn;
                    nxt_phase = adv_phase;
                    nxt_pol   = adv_pol;
                    if (amp_dn == 8'd0) nxt_state = SILENT;
                end
            end
            default: nxt_state = SILENT;
        endcase
    end

    assign mag    = 32'(nxt_amp) << AMP_SHIFT;
    assign sample = nxt_pol ? mag : -mag;

    assign write_audio_out = pending & audio_out_allowed;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state                   <= SILENT;
            keys_q                  <= '0;
            count                   <= '0;
            amp                     <= '0;
            phase                   <= '0;
            pol                     <= 1'b1;
            note                    <= '0;
            pending                 <= 1'b0;
            overrun                 <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
        end else begin
            keys_q <= keys;
            count  <= tick ? '0 : count + CW'(1);
            if (tick) begin
                state                   <= nxt_state;
                amp                     <= nxt_amp;
                phase                   <= nxt_phase;
                pol                     <= nxt_pol;
                note                    <= nxt_note;
                left_channel_audio_out  <= sample;
                right_channel_audio_out <= sample;
                pending                 <= 1'b1;
                // A sample still waiting with no room this cycle is lost to the new one.
                if (pending && !audio_out_allowed) overrun <= 1'b1;
            end else if (write_audio_out) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_tone_gen.sv
// Randomised bench for key_tone_gen: a tick-level behavioural model of the tone
// generator predicts every output each cycle.
module tb_key_tone_gen;

    localparam int DIV   = 4;
    localparam int STEP  = 4;
    localparam int SHIFT = 20;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] keys = '0;
    logic        allowed = 1'b1;
    logic        write_audio_out;
    logic [31:0] left_out, right_out;
    logic [3:0]  note;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    key_tone_gen #(.SAMPLE_DIV(DIV), .AMP_STEP(STEP), .AMP_SHIFT(SHIFT)) dut (
        .clock                   (clock),
        .resetn                  (resetn),
        .keys                    (keys),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .note                    (note),
        .overrun                 (overrun)
    );

    always #5 clock = ~clock;

    // Model state: mode 0 silent, 1 play, 2 release.
    int hp[16] = '{39, 41, 43, 46, 49, 51, 55, 58, 61, 65, 69, 73, 77, 82, 87, 92};
    int          m_mode, m_amp, m_phase, m_note, m_count;
    bit          m_pos, m_pending, m_overrun;
    logic [15:0] m_keys;
    logic [31:0] m_sample;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int top_key(input logic [15:0] k);
        for (int i = 15; i >= 0; i--) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_amp = 0; m_phase = 0; m_note = 0; m_count = 0;
        m_pos = 1; m_pending = 0; m_overrun = 0; m_keys = '0; m_sample = '0;
    endtask

    task automatic advance();
        if (m_phase == hp[m_note] - 1) begin
            m_phase = 0;
            m_pos = !m_pos;
        end else begin
            m_phase++;
        end
    endtask

    task automatic model_tick();
        int s;
        int mag;
        s = top_key(m_keys);
        case (m_mode)
            0: begin
                m_amp = 0;
                if (s >= 0) begin m_mode = 1; m_note = s; m_phase = 0; m_pos = 1; end
            end
            1: begin
                m_amp = (m_amp + STEP > 255) ? 255 : m_amp + STEP;
                if (s < 0) begin m_mode = 2; advance(); end
                else if (s != m_note) begin m_note = s; m_phase = 0; end
                else advance();
            end
            default: begin
                if (s >= 0) begin m_mode = 1; m_note = s; m_phase = 0; end
                else begin
                    m_amp = (m_amp - STEP < 0) ? 0 : m_amp - STEP;
                    advance();
                    if (m_amp == 0) m_mode = 0;
                end
            end
        endcase
        mag = m_amp * (1 << SHIFT);
        m_sample = m_pos ? 32'(mag) : 32'(-mag);
    endtask

    task automatic model_edge();
        bit tick;
        tick = (m_count == DIV - 1);
        if (tick) begin
            model_tick();
            if (m_pending && !allowed) m_overrun = 1;
            m_pending = 1;
        end else if (m_pending && allowed) begin
            m_pending = 0;
        end
        m_count = (m_count + 1) % DIV;
        m_keys = keys;
    endtask

    task automatic compare_all();
        check("write", 32'(write_audio_out), 32'(m_pending && allowed));
        check("left", left_out, m_sample);
        check("right", right_out, m_sample);
        check("note", 32'(note), 32'(m_note));
        check("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n * DIV; i++) step();
    endtask

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    initial begin
        int writes;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
        resetn = 1'b1;

        // Idle: zeros flow out every tick.
        run_ticks(10);

        // Attack on h up to saturation.
        keys = 16'h0001;
        run_ticks(75);
        check("sat_level", magnitude(left_out), 32'(255) << SHIFT);

        // Priority q over h, then drop back to h mid-period.
        keys = 16'h8001;
        run_ticks(50);
        check("prio_note", 32'(note), 32'd15);
        keys = 16'h0001;
        run_ticks(40);

        // Release to silence, then release interrupted by a new key.
        keys = 16'h0000;
        run_ticks(70);
        check("silent", left_out, 32'd0);
        keys = 16'h0400;
        run_ticks(70);
        keys = 16'h0000;
        run_ticks(12);
        keys = 16'h0100;
        run_ticks(20);

        // Backpressure: no writes while blocked, overrun set, one write after release.
        allowed = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            writes += int'(write_audio_out);
        end
        check("blocked_writes", 32'(writes), 32'd0);
        check("overrun_set", 32'(overrun), 32'd1);
        allowed = 1'b1;
        #1;
        check("single_write", 32'(write_audio_out), 32'd1);
        step();
        check("write_cleared", 32'(write_audio_out), 32'd0);

        // Randomised keys and flow control.
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       keys = '0;
                    1:       keys = 16'(1 << $urandom_range(0, 15));
                    default: keys = 16'($urandom);
                endcase
            end
            for (int c = 0; c < DIV; c++) begin
                allowed = ($urandom_range(0, 9) != 0);
                step();
            end
        end

        // Reset while a PLAY sample is pending.
        keys = 16'h0001;
        allowed = 1'b1;
        run_ticks(30);
        allowed = 1'b0;
        for (int i = 0; i < DIV + 1 && !m_pending; i++) step();
        check("pending_before_reset", 32'(m_pending), 32'd1);
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        allowed = 1'b1;
        #1;
        compare_all();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
        resetn = 1'b1;
        run_ticks(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_tone_gen.md
# key_tone_gen

Downstream stage of the keyboard sampler: takes the 16 key-held lines from the PS/2 keyboard tracker (q…h), selects one note by fixed priority, and synthesises a square-wave tone with a linear attack/release envelope. Produces one signed PCM sample per sample tick and hands it to the audio codec output FIFO through a ready/write handshake. Sits between the sampler's key-select logic and the audio controller.

## Interface
- SAMPLE_DIV, 1042, clock cycles per sample tick (50 MHz / 1042 ≈ 48 kHz)
- AMP_STEP, 4, envelope increment/decrement per sample tick
- AMP_SHIFT, 20, left shift applied to 8-bit amplitude to form the sample
- clock  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous, active-low reset
- keys  in  16  key-held flags; bit 15 = q, bit 14 = w, …, bit 0 = h
- audio_out_allowed  in  1  codec FIFO has room for one sample
- write_audio_out  out  1  sample write strobe
- left_channel_audio_out  out  32  signed sample
- right_channel_audio_out  out  32  identical to left
- note  out  4  index of the currently sounding note (15 = q)
- overrun  out  1  sticky: a sample was dropped

## Operation
- keys registered once (keys_q); all decisions use keys_q.
- Priority: highest set bit of keys_q wins; any_key = |keys_q.
- Tick counter 0..SAMPLE_DIV-1, wraps; tick = (count == SAMPLE_DIV-1). Free-running, including in SILENT.
- Half-period table (sample ticks), note index 15..0 = C4..D#5: q 92, w 87, e 82, r 77, t 73, y 69, u 65, i 61, o 58, p 55, a 51, s 49, d 46, f 43, g 41, h 39.
- FSM, evaluated only on tick:
  - SILENT: amp = 0. any_key → PLAY; load note, phase = 0, pol = 1.
  - PLAY: amp = min(amp + AMP_STEP, 255). Selected index ≠ note → load new note, phase = 0, keep amp and pol. !any_key → RELEASE.
  - RELEASE: amp = max(amp − AMP_STEP, 0). any_key → PLAY (load note, phase = 0, amp kept). amp reaches 0 → SILENT.
- Phase: in PLAY/RELEASE, phase increments per tick; at phase == half_period−1, phase ← 0 and pol toggles.
- Sample (computed from post-update amp/pol): pol=1 → +(amp << AMP_SHIFT), pol=0 → −(amp << AMP_SHIFT), 32-bit two's complement. SILENT gives 0.
- Every tick produces a sample, including SILENT (zeros keep the codec fed).
- Handshake: on each tick the sample is latched into the output registers and pending is set. write_audio_out = pending & audio_out_allowed (combinational); pending clears on that edge. While pending, the output registers hold their value.
- A tick arriving while pending is still set overwrites the output registers, keeps pending set, and sets overrun. overrun clears only on reset.

## Timing
- Reset (resetn low, async): FSM SILENT, count 0, amp 0, phase 0, pol 1, note 0, pending 0, keys_q 0, both channels 0, write_audio_out 0, overrun 0.
- Key-to-FSM latency: 1 cycle (keys_q) plus wait for the next tick.
- Tick at cycle T: state, amp, phase, pol and channels update at the edge ending T; pending = 1 from T+1. write_audio_out is high in T+1 if audio_out_allowed, else in the first later cycle where allowed = 1. It is exactly one cycle wide per sample.
- Attack 0→255 takes 64 ticks at AMP_STEP = 4 (the last step saturates from 252).
- resetn asserted mid-handshake drops the pending sample with no write.

## Test plan
- Reset, keys = 0, allowed = 1, SAMPLE_DIV = 4 → one write every 4 cycles, samples all 0, note 0, overrun 0.
- keys = 0x0001 (h), SAMPLE_DIV = 4 → PLAY, note 0. Samples positive for 39 ticks, then negative, magnitude (4·k) << 20 on tick k until 255 << 20.
- keys = 0x8001 (q+h) → note 15, half-period 92. Then change to 0x0001 mid-cycle → note 0, phase restarts, amp continuous.
- Release from amp 255 → amp falls 4 per tick; SILENT after 64 ticks; samples then 0. Key re-pressed during RELEASE → PLAY, amp resumes from its current value.
- allowed = 0 for 10 cycles with SAMPLE_DIV = 4 → no writes, overrun = 1. Raise allowed → single write of the most recent sample.
- resetn pulsed low while pending in PLAY → all outputs 0 immediately, no write, FSM SILENT.
